// File: rtl/eval_rr_scheduler.sv
// Round-robin front end for one shared 3-input evaluator.
// Grants one requester, evaluates its operand, pulses the result back.
module eval_rr_scheduler #(
    parameter int NREQ  = 4,
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [3*NREQ-1:0] req_op,
    output logic [NREQ-1:0]   req_ready,
    output logic [NREQ-1:0]   rsp_valid,
    output logic              rsp_x,
    output logic              busy,
    output logic [CNT_W-1:0]  eval_count
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        IDLE,
        EVAL,
        DONE
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [IW-1:0] ptr;
    logic [IW-1:0] g_r;
    logic [IW-1:0] win;
    logic [IW-1:0] idx;
    logic          found;
    logic [2:0]    op_r;
    logic          x;

    // Search starts just after the last grant and wraps.
    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = '0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = IW'((int'(ptr) + k) % NREQ);
            if (!found && req_valid[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    assign x = (~op_r[2] & op_r[0]) | (~op_r[1] & op_r[0]) |
               (~op_r[2] & op_r[1]) | (op_r[2] & ~op_r[0]);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Strobes are masked during reset so an aborted job never responds.
    always_comb begin
        state_nxt = state;
        req_ready = '0;
        rsp_valid = '0;
        busy      = 1'b0;
        unique case (state)
            IDLE: begin
                if (found) begin
                    req_ready = rst_n ? (NREQ'(1) << win) : '0;
                    state_nxt = EVAL;
                end
            end
            EVAL: begin
                busy      = 1'b1;
                state_nxt = DONE;
            end
            DONE: begin
                busy      = 1'b1;
                rsp_valid = rst_n ? (NREQ'(1) << g_r) : '0;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr        <= IW'(NREQ - 1);
            g_r        <= '0;
            op_r       <= '0;
            rsp_x      <= 1'b0;
            eval_count <= '0;
        end else begin
            if (state == IDLE && found) begin
                ptr  <= win;
                g_r  <= win;
                op_r <= req_op[int'(win)*3 +: 3];
            end
            if (state == EVAL) begin
                rsp_x <= x;
            end
            if (state == DONE && eval_count != '1) begin
                eval_count <= eval_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_eval_rr_scheduler.sv
// Scoreboard bench for eval_rr_scheduler: directed scenarios then
// randomized requesters against a round-robin reference model.
module tb_eval_rr_scheduler;

    localparam int NREQ  = 4;
    localparam int CNT_W = 16;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [NREQ-1:0]   req_valid = '0;
    logic [3*NREQ-1:0] req_op = '0;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ-1:0]   rsp_valid;
    logic              rsp_x;
    logic              busy;
    logic [CNT_W-1:0]  eval_count;

    logic [NREQ-1:0]   s_ready;
    logic [NREQ-1:0]   s_rsp_valid;
    logic              s_rsp_x;
    logic              s_busy;
    logic [1:0]        s_count;

    eval_rr_scheduler #(.NREQ(NREQ), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_op(req_op),
        .req_ready(req_ready), .rsp_valid(rsp_valid),
        .rsp_x(rsp_x), .busy(busy), .eval_count(eval_count)
    );

    eval_rr_scheduler #(.NREQ(NREQ), .CNT_W(2)) u_sat (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_op(req_op),
        .req_ready(s_ready), .rsp_valid(s_rsp_valid),
        .rsp_x(s_rsp_x), .busy(s_busy), .eval_count(s_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int g;
        int x;
        int due;
    } exp_t;

    exp_t sb[$];
    int   acc_g[$];
    int   acc_c[$];
    int   n_run = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   rsp_cnt = 0;
    int   last_x = -1;
    int   last_g = -1;
    int   m_phase = 0;
    int   m_ptr = NREQ - 1;
    int   m_cnt = 0;

    function automatic void check(string name, int act, int exp);
        n_run++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)",
                     name, act, exp, cyc);
        end
    endfunction

    function automatic int rr_pick(int last, logic [NREQ-1:0] v);
        for (int k = 1; k <= NREQ; k++) begin
            if (v[(last + k) % NREQ]) return (last + k) % NREQ;
        end
        return -1;
    endfunction

    function automatic int model_x(logic [2:0] op);
        return (op[2] == op[1] && op[1] == op[0]) ? 0 : 1;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: requester-level view of grants, latency and count.
    always @(negedge clk) begin
        int   g;
        exp_t e;
        check("ready_onehot", int'($onehot0(req_ready)), 1);
        check("rsp_onehot", int'($onehot0(rsp_valid)), 1);
        check("ready_rsp_excl",
              int'(req_ready != 0 && rsp_valid != 0), 0);
        if (req_ready != 0) begin
            for (int i = 0; i < NREQ; i++)
                if (req_ready[i]) begin
                    acc_g.push_back(i);
                    acc_c.push_back(cyc);
                end
        end
        if (!rst_n) begin
            check("ready_in_reset", int'(req_ready), 0);
            sb.delete();
            m_phase = 0;
            m_ptr   = NREQ - 1;
            m_cnt   = 0;
        end else begin
            check("busy", int'(busy), int'(m_phase != 0));
            check("eval_count", int'(eval_count), m_cnt);
            if (m_phase == 0) begin
                if (req_valid != 0) begin
                    g = rr_pick(m_ptr, req_valid);
                    check("grant", int'(req_ready), 1 << g);
                    e.g   = g;
                    e.x   = model_x(req_op[3*g +: 3]);
                    e.due = cyc + 2;
                    sb.push_back(e);
                    m_ptr   = g;
                    m_phase = 2;
                end else begin
                    check("ready_idle", int'(req_ready), 0);
                end
            end else begin
                check("ready_busy", int'(req_ready), 0);
                if (m_phase == 1) m_cnt = (m_cnt == CMAX) ? CMAX : m_cnt + 1;
                m_phase--;
            end
        end
    end

    // Monitor: pops the scoreboard whenever a response appears.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            check("rsp_in_reset", int'(rsp_valid), 0);
        end else if (rsp_valid != 0) begin
            if (sb.size() == 0) begin
                check("unexpected_rsp", int'(rsp_valid), 0);
            end else begin
                e = sb.pop_front();
                check("rsp_valid", int'(rsp_valid), 1 << e.g);
                check("rsp_x", int'(rsp_x), e.x);
                check("rsp_latency", cyc, e.due);
                last_x = int'(rsp_x);
                last_g = e.g;
                rsp_cnt++;
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cycles(2);
        rst_n = 1'b1;
    endtask

    task automatic issue(input int i, input logic [2:0] op);
        bit got;
        got = 1'b0;
        req_op[3*i +: 3] = op;
        req_valid[i] = 1'b1;
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clk);
            if (req_ready[i]) got = 1'b1;
        end
        check("accept_timeout", int'(got), 1);
        @(posedge clk);
        #1;
        req_valid[i] = 1'b0;
    endtask

    task automatic check_log(string name, int idx, int g, int dc, int c0);
        if (acc_g.size() > idx) begin
            check({name, "_g"}, acc_g[idx], g);
            check({name, "_c"}, acc_c[idx] - c0, dc);
        end else begin
            check({name, "_missing"}, acc_g.size(), idx + 1);
        end
    endtask

    initial begin
        logic [7:0]      exp_t2;
        logic [NREQ-1:0] hs;
        int              c0;
        int              snap;

        exp_t2 = 8'b0111_1110;
        cycles(3);
        rst_n = 1'b1;
        #1;
        check("rst_ready", int'(req_ready), 0);
        check("rst_rsp", int'(rsp_valid), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_count", int'(eval_count), 0);
        check("rst_x", int'(rsp_x), 0);

        issue(0, 3'b000);
        cycles(2);
        check("t1_x0", last_x, 0);
        check("t1_g", last_g, 0);
        issue(0, 3'b101);
        cycles(2);
        check("t1_x1", last_x, 1);

        do_reset();
        for (int op = 0; op < 8; op++) begin
            issue(2, 3'(op));
            cycles(2);
            check("t2_x", last_x, int'(exp_t2[op]));
            check("t2_g", last_g, 2);
            if (op < 5) check("t6_sat", int'(s_count), (op + 1 > 3) ? 3 : op + 1);
        end
        check("t2_count", int'(eval_count), 8);

        do_reset();
        acc_g.delete();
        acc_c.delete();
        req_op = 12'o1357;
        req_valid = '1;
        c0 = cyc;
        cycles(13);
        req_valid = '0;
        cycles(4);
        check("t3_n", acc_g.size(), 5);
        for (int k = 0; k < 5; k++) check_log("t3", k, k % NREQ, 3 * k, c0);

        issue(1, 3'b011);
        cycles(3);
        acc_g.delete();
        acc_c.delete();
        req_valid = 4'b1010;
        c0 = cyc;
        cycles(7);
        req_valid = '0;
        cycles(4);
        check_log("t4", 0, 3, 0, c0);
        check_log("t4", 1, 1, 3, c0);
        check_log("t4", 2, 3, 6, c0);

        do_reset();
        snap = rsp_cnt;
        issue(0, 3'b110);
        rst_n = 1'b0;
        cycles(1);
        rst_n = 1'b1;
        cycles(3);
        check("t5_no_rsp", rsp_cnt, snap);
        check("t5_count", int'(eval_count), 0);
        check("t5_busy", int'(busy), 0);
        acc_g.delete();
        acc_c.delete();
        req_valid = 4'b0011;
        cycles(1);
        req_valid = '0;
        cycles(3);
        check_log("t5", 0, 0, 0, acc_c.size() > 0 ? acc_c[0] : 0);

        for (int t = 0; t < 800; t++) begin
            @(negedge clk);
            hs = req_valid & req_ready;
            @(posedge clk);
            #1;
            rst_n = ($urandom_range(150) != 0);
            for (int i = 0; i < NREQ; i++) begin
                if (hs[i]) begin
                    req_valid[i] = ($urandom_range(1) == 1);
                    req_op[3*i +: 3] = 3'($urandom_range(7));
                end else if (req_valid[i]) begin
                    if ($urandom_range(15) == 0) req_valid[i] = 1'b0;
                end else if ($urandom_range(3) == 0) begin
                    req_valid[i] = 1'b1;
                    req_op[3*i +: 3] = 3'($urandom_range(7));
                end
            end
        end
        rst_n = 1'b1;
        req_valid = '0;
        cycles(6);
        check("sb_drained", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

// File: doc/eval_rr_scheduler.md
Name: eval_rr_scheduler

Overview:
Round-robin scheduler that shares one 3-input boolean evaluator, x = (~a&c)|(~b&c)|(~a&b)|(a&~c), among NREQ requesters. Equivalently, x = 1 unless a==b==c.
- Each requester presents a 3-bit operand {a,b,c} with a valid/ready handshake.
- The block arbitrates, latches the winning operand, evaluates, and returns a one-cycle response pulse to the winner.
- It sits between requester logic and the shared logic cell and also keeps a saturating evaluation counter.

Parameters:
NREQ, 4, number of requesters (2..8).
CNT_W, 16, width of the saturating evaluation counter.

Ports:
clk  input  1  rising-edge clock.
rst_n  input  1  synchronous reset, active-low.
req_valid  input  NREQ  per-requester request; bit i belongs to requester i.
req_op  input  3*NREQ  operands; slice [3i+2:3i] = {a,b,c} of requester i.
req_ready  output  NREQ  one-hot accept strobe; handshake completes when req_valid[i] & req_ready[i].
rsp_valid  output  NREQ  one-hot, one-cycle result strobe to the granted requester.
rsp_x  output  1  evaluator result; meaningful only while rsp_valid != 0.
busy  output  1  high in EVAL and DONE.
eval_count  output  CNT_W  number of completed evaluations, saturating.

Behaviour:
- Reset (rst_n low at a clock edge):
  - state=IDLE; req_ready=0; rsp_valid=0; rsp_x=0; busy=0; eval_count=0.
  - Last-grant pointer ptr=NREQ-1, so requester 0 wins first.
  - Latched operand and grant index cleared.
- FSM states: IDLE, EVAL, DONE.
- IDLE:
  - If any req_valid bit is set, select the winner g = first set bit searching ptr+1, ptr+2, ... with wrap modulo NREQ.
  - req_ready[g]=1 combinationally in this cycle; all other req_ready bits are 0.
  - At the edge: latch req_op slice g into op_r, store g, set ptr=g, go to EVAL.
  - If no request is valid, stay in IDLE; req_ready=0.
- EVAL:
  - Evaluator driven from op_r (a=op_r[2], b=op_r[1], c=op_r[0]).
  - At the edge: register the result into rsp_x, go to DONE.
  - req_ready=0 throughout.
- DONE:
  - rsp_valid[g]=1 for exactly this cycle; rsp_x holds the result.
  - At the edge: eval_count increments, holding at all-ones once reached; go to IDLE.
  - rsp_x holds its value until the next EVAL→DONE edge.
- Latency and throughput:
  - Accept in cycle T, rsp_valid in cycle T+2.
  - Maximum throughput is one evaluation per 3 cycles.
  - With continuous requests, the next accept is in T+3.
- Requester rules:
  - req_op must be held stable while req_valid is high and not yet accepted.
  - A requester may drop req_valid before acceptance; no grant is then issued to it.
  - req_valid is ignored outside IDLE; no queuing inside the block.
- Simultaneous events:
  - A requester that just received rsp_valid may re-request; it competes by round-robin in the following IDLE cycle.
  - Fairness: with all requesters continuously valid, grants go 0,1,...,NREQ-1,0,...
- Reset mid-operation: rst_n low in EVAL or DONE aborts the operation. No rsp_valid is issued, and the pointer and counter return to reset values.
- Invariants (for assertions): req_ready and rsp_valid are each one-hot or zero; both are never nonzero in the same cycle.

Test Plan:
1. Only req_valid[0]=1, op=3'b000 → req_ready[0] in cycle T, rsp_valid=4'b0001 in T+2, rsp_x=0. Repeat with op=3'b101 → rsp_x=1.
2. Requester 2 sweeps op 0..7 sequentially → rsp_x sequence 0,1,1,1,1,1,1,0; eval_count=8; each rsp_valid=4'b0100.
3. All four req_valid held high for 12 cycles → accepts in cycles 0,3,6,9 to requesters 0,1,2,3; next accept goes to 0.
4. Last grant=1, then req_valid=4'b1010 → grant 3, then 1, then 3.
5. rst_n low for one cycle while in EVAL → no rsp_valid pulse; eval_count=0; busy=0. Next request from 0 and 1 together → grant to 0.
6. CNT_W=2, 5 evaluations → eval_count reads 1,2,3,3,3.
